// File: rtl/jedro_pipe_pkg.sv
// Shared types and constants for the jedro pipeline glue blocks.
package jedro_pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main slot drives m_data, skid slot
// catches the word that arrives while downstream stalls. Upstream ready is
// a flop, so m_ready never reaches s_ready combinationally.
module skid_buffer
  import jedro_pipe_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic [1:0]            count
);

  skid_state_t           state_q, state_d;
  logic [WORD_WIDTH-1:0] main_q, main_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  s_ready_q;

  logic s_fire, m_fire;

  assign s_fire = s_valid & s_ready_q;
  assign m_fire = m_valid & m_ready;

  // Next-state and slot loads; flush squashes everything in flight.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (s_fire) begin
            main_d  = s_data;
            state_d = SKID_BUSY;
          end
        end
        SKID_BUSY: begin
          if (s_fire && m_fire) begin
            main_d = s_data;
          end else if (s_fire) begin
            skid_d  = s_data;
            state_d = SKID_FULL;
          end else if (m_fire) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // s_ready is low here, so only the drain side can move.
          if (m_fire) begin
            main_d  = skid_q;
            state_d = SKID_BUSY;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // State, slots and registered upstream ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= SKID_EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= (state_d != SKID_FULL);
    end
  end

  // Occupancy decode.
  always_comb begin
    count = 2'd0;
    case (state_q)
      SKID_BUSY: count = 2'd1;
      SKID_FULL: count = 2'(SKID_DEPTH);
      default:   count = 2'd0;
    endcase
  end

  assign s_ready = s_ready_q;
  assign m_valid = (state_q != SKID_EMPTY);
  assign m_data  = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed cases plus a random soak,
// with a reference queue tracking the words held by the buffer.
module tb_skid_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic        rdy_exp  = 1'b0;
  logic        rst_flag = 1'b1;

  skid_buffer #(.WORD_WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: checks the outputs against the model, then advances it
  // with the handshakes that the coming edge will see.
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      rdy_exp  = 1'b0;
      rst_flag = 1'b1;
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("s_ready", 32'(s_ready), 32'(rdy_exp));
    if (q.size() != 0) chk("m_data_front", m_data, q[0]);
    else if (rst_flag) chk("m_data_rst", m_data, 32'h0);
    if (rstn) begin
      if (flush) begin
        q.delete();
        rst_flag = 1'b1;
        rdy_exp  = 1'b1;
      end else begin
        if (m_valid && m_ready && q.size() != 0) void'(q.pop_front());
        if (s_valid && s_ready) begin
          q.push_back(s_data);
          rst_flag = 1'b0;
        end
        rdy_exp = (q.size() != 2);
      end
    end
  end

  initial begin
    // Reset release with upstream already valid.
    #1 rstn = 1'b0;
    s_valid = 1'b1; s_data = 32'h55;
    repeat (3) cyc();
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    rstn = 1'b1;
    cyc();
    chk("rel_s_ready", 32'(s_ready), 32'h1);
    chk("rel_no_accept", 32'(m_valid), 32'h0);
    cyc();
    chk("rel_first", m_data, 32'h55);
    s_valid = 1'b0; m_ready = 1'b1;
    cyc();

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      cyc();
      chk("strm_data", m_data, 32'(i));
      chk("strm_count", 32'(count), 32'h1);
      chk("strm_ready", 32'(s_ready), 32'h1);
    end
    s_valid = 1'b0;
    cyc();

    // Backpressure fills both slots.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA; cyc();
    s_data = 32'hB; cyc();
    s_valid = 1'b0;
    chk("bp_count", 32'(count), 32'h2);
    chk("bp_ready", 32'(s_ready), 32'h0);
    chk("bp_hold", m_data, 32'hA);
    cyc();
    chk("bp_hold2", m_data, 32'hA);
    m_ready = 1'b1;
    cyc();
    chk("bp_drain1", m_data, 32'hB);
    chk("bp_cnt1", 32'(count), 32'h1);
    chk("bp_ready1", 32'(s_ready), 32'h1);
    cyc();
    chk("bp_empty", 32'(count), 32'h0);

    // Simultaneous fire in BUSY.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h10; cyc();
    s_data = 32'h11; m_ready = 1'b1; cyc();
    chk("sim_data", m_data, 32'h11);
    chk("sim_count", 32'(count), 32'h1);
    s_valid = 1'b0; cyc();

    // Flush while full, with a word offered in the flush cycle.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h20; cyc();
    s_data = 32'h21; cyc();
    chk("fl_full", 32'(count), 32'h2);
    s_data = 32'h22; flush = 1'b1; cyc();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl_count", 32'(count), 32'h0);
    chk("fl_m_valid", 32'(m_valid), 32'h0);
    chk("fl_m_data", m_data, 32'h0);
    chk("fl_ready", 32'(s_ready), 32'h1);
    cyc();
    chk("fl_no_22", 32'(m_valid), 32'h0);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data  = $urandom;
      flush   = ($urandom_range(0, 127) == 0);
      cyc();
      if (count > 2'd2) chk("soak_cnt_max", 32'(count), 32'h2);
    end
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) cyc();
    chk("soak_drained", 32'(count), 32'h0);

    // Asynchronous reset mid-transfer.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h77; cyc();
    s_valid = 1'b0;
    chk("ar_loaded", m_data, 32'h77);
    rstn = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'h0);
    chk("ar_s_ready", 32'(s_ready), 32'h0);
    chk("ar_m_data", m_data, 32'h0);
    chk("ar_count", 32'(count), 32'h0);
    cyc(); cyc();
    rstn = 1'b1;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
